traffic_phase_ctrl: RTL and testbench



---
 rtl/traffic_phase_ctrl.sv | 151 +++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-road intersection phase sequencer with internal phase timer
// Optional pedestrian walk phase is enabled by defining PED_WALK_EN.
module traffic_phase_ctrl #(
    parameter int T_MAIN_MIN_GREEN = 20,
    parameter int T_SIDE_GREEN     = 15,
    parameter int T_YELLOW         = 10,
    parameter int T_ALL_RED        = 2,
    parameter int T_WALK           = 12,
    parameter int CNT_W            = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       side_sensor,
    input  logic       force_main,
`ifdef PED_WALK_EN
    input  logic       ped_btn,
    output logic       walk,
`endif
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] phase,
    output logic       phase_done,
    output logic       req_pending
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5,
        WALK        = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_pending_q, req_pending_d;
    logic               phase_done_q, phase_done_d;
    logic               cnt_zero;
    logic               enter;
`ifdef PED_WALK_EN
    logic               ped_pending_q, ped_pending_d;
`endif

    // Counter value loaded on entry to a state: its duration minus one.
    function automatic logic [CNT_W-1:0] load_val(input state_t s);
        case (s)
            MAIN_GREEN:  load_val = CNT_W'(T_MAIN_MIN_GREEN - 1);
            MAIN_YELLOW: load_val = CNT_W'(T_YELLOW - 1);
            ALL_RED_A:   load_val = CNT_W'(T_ALL_RED - 1);
            SIDE_GREEN:  load_val = CNT_W'(T_SIDE_GREEN - 1);
            SIDE_YELLOW: load_val = CNT_W'(T_YELLOW - 1);
            WALK:        load_val = CNT_W'(T_WALK - 1);
            default:     load_val = CNT_W'(T_ALL_RED - 1);
        endcase
    endfunction

    assign cnt_zero = (cnt_q == '0);

    // Next-state, counter and request-latch logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GREEN:  if (run && cnt_zero && (req_pending_q || side_sensor)) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (run && cnt_zero) state_d = ALL_RED_A;
            ALL_RED_A:   if (run && cnt_zero) state_d = SIDE_GREEN;
            SIDE_GREEN:  if (run && (cnt_zero || force_main)) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (run && cnt_zero) state_d = ALL_RED_B;
`ifdef PED_WALK_EN
            ALL_RED_B:   if (run && cnt_zero) state_d = ped_pending_q ? WALK : MAIN_GREEN;
            WALK:        if (run && cnt_zero) state_d = MAIN_GREEN;
`else
            ALL_RED_B:   if (run && cnt_zero) state_d = MAIN_GREEN;
`endif
            // Unreachable encodings fall back to the clearance phase before main green.
            default:     state_d = ALL_RED_B;
        endcase

        enter = (state_d != state_q);

        if (enter)
            cnt_d = load_val(state_d);
        else if (run && !cnt_zero)
            cnt_d = cnt_q - 1'b1;
        else
            cnt_d = cnt_q;

        phase_done_d = run && enter;

        // Clear on the hand-over to side green wins over a simultaneous new request.
        if (state_q == ALL_RED_A && state_d == SIDE_GREEN)
            req_pending_d = 1'b0;
        else if (side_sensor && state_q != SIDE_GREEN)
            req_pending_d = 1'b1;
        else
            req_pending_d = req_pending_q;

`ifdef PED_WALK_EN
        if (state_d == WALK && state_q != WALK)
            ped_pending_d = 1'b0;
        else if (ped_btn && state_q != WALK)
            ped_pending_d = 1'b1;
        else
            ped_pending_d = ped_pending_q;
`endif
    end

    // State registers with asynchronous reset to the main-green rest state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MAIN_GREEN;
            cnt_q         <= CNT_W'(T_MAIN_MIN_GREEN - 1);
            req_pending_q <= 1'b0;
            phase_done_q  <= 1'b0;
`ifdef PED_WALK_EN
            ped_pending_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_pending_q <= req_pending_d;
            phase_done_q  <= phase_done_d;
`ifdef PED_WALK_EN
            ped_pending_q <= ped_pending_d;
`endif
        end
    end

    // Lights decoded straight from the registered state.
    always_comb begin
        main_light = 3'b100;
        side_light = 3'b100;
        case (state_q)
            MAIN_GREEN:  main_light = 3'b001;
            MAIN_YELLOW: main_light = 3'b010;
            SIDE_GREEN:  side_light = 3'b001;
            SIDE_YELLOW: side_light = 3'b010;
            default:     ;
        endcase
    end

    assign phase       = state_q;
    assign phase_done  = phase_done_q;
    assign req_pending = req_pending_q;
`ifdef PED_WALK_EN
    assign walk        = (state_q == WALK);
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b1;
    logic       side_sensor = 1'b0;
    logic       force_main = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [2:0] phase;
    logic       phase_done;
    logic       req_pending;
`ifdef PED_WALK_EN
    logic       ped_btn = 1'b0;
    logic       walk;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_phase_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .side_sensor (side_sensor),
        .force_main  (force_main),
`ifdef PED_WALK_EN
        .ped_btn     (ped_btn),
        .walk        (walk),
`endif
        .main_light  (main_light),
        .side_light  (side_light),
        .phase       (phase),
        .phase_done  (phase_done),
        .req_pending (req_pending)
    );

    // Hand-derived phase timeline for one full cycle started from reset (cycle 0).
    function automatic logic [2:0] seq_phase(input int c);
        if (c < 20)      seq_phase = 3'd0;
        else if (c < 30) seq_phase = 3'd1;
        else if (c < 32) seq_phase = 3'd2;
        else if (c < 47) seq_phase = 3'd3;
        else if (c < 57) seq_phase = 3'd4;
        else if (c < 59) seq_phase = 3'd5;
        else             seq_phase = 3'd0;
    endfunction

    function automatic logic [2:0] exp_main(input logic [2:0] p);
        case (p)
            3'd0:    exp_main = 3'b001;
            3'd1:    exp_main = 3'b010;
            default: exp_main = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input logic [2:0] p);
        case (p)
            3'd3:    exp_side = 3'b001;
            3'd4:    exp_side = 3'b010;
            default: exp_side = 3'b100;
        endcase
    endfunction

    // Leaves the bench at a falling edge, just after release: this is cycle 0.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b1;
        side_sensor = 1'b0;
        force_main = 1'b0;
`ifdef PED_WALK_EN
        ped_btn = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", phase); end
        n_checks++;
        if (main_light !== 3'b001 || side_light !== 3'b100) begin
            n_fail++; $display("FAIL reset_lights got %b/%b want 001/100", main_light, side_light);
        end
        n_checks++;
        if (req_pending !== 1'b0 || phase_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got req=%b done=%b want 0/0", req_pending, phase_done);
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            if (phase !== 3'd0 || phase_done !== 1'b0 || main_light !== 3'b001 || side_light !== 3'b100)
                bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL idle_rest got %0d bad cycles want 0", bad); end
        // Request after the minimum green has expired is honoured on the next edge.
        side_sensor = 1'b1;
        @(negedge clk);
        side_sensor = 1'b0;
        n_checks++;
        if (phase !== 3'd1 || phase_done !== 1'b1) begin
            n_fail++; $display("FAIL idle_late_req got phase=%0d done=%b want 1/1", phase, phase_done);
        end
    endtask

    task automatic test_full_cycle();
        do_reset();
        for (int c = 0; c < 66; c++) begin
            logic [2:0] ep;
            logic       ed, er;
            side_sensor = (c == 5);
            ep = seq_phase(c);
            ed = (c > 0) && (ep != seq_phase(c - 1));
            er = (c >= 6 && c < 32);
            n_checks++;
            if (phase !== ep || phase_done !== ed || req_pending !== er ||
                main_light !== exp_main(ep) || side_light !== exp_side(ep)) begin
                n_fail++;
                $display("FAIL full_cycle c=%0d got ph=%0d done=%b req=%b lights=%b/%b want ph=%0d done=%b req=%b lights=%b/%b",
                         c, phase, phase_done, req_pending, main_light, side_light,
                         ep, ed, er, exp_main(ep), exp_side(ep));
            end
            @(negedge clk);
        end
        side_sensor = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int bad = 0;
        do_reset();
        side_sensor = 1'b1;
        for (int c = 0; c < 178; c++) begin
            logic [2:0] ep;
            ep = seq_phase(c % 59);
            if (phase !== ep) bad++;
            if (c >= 1 && c <= 118 && phase_done === 1'b1) pulses++;
            @(negedge clk);
        end
        side_sensor = 1'b0;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_period got %0d bad cycles want 0", bad); end
        n_checks++;
        if (pulses != 12) begin n_fail++; $display("FAIL b2b_pulses got %0d want 12", pulses); end
    endtask

    task automatic test_force_main();
        do_reset();
        for (int c = 0; c < 50; c++) begin
            side_sensor = (c == 0);
            force_main  = (c >= 1 && c <= 5) || (c == 34);
            if (c == 10) begin
                n_checks++;
                if (phase !== 3'd0) begin n_fail++; $display("FAIL force_ignored got %0d want 0", phase); end
            end
            if (c == 20) begin
                n_checks++;
                if (phase !== 3'd1) begin n_fail++; $display("FAIL force_yellow_at20 got %0d want 1", phase); end
            end
            if (c == 34) begin
                n_checks++;
                if (phase !== 3'd3) begin n_fail++; $display("FAIL force_green3 got %0d want 3", phase); end
            end
            if (c == 35) begin
                n_checks++;
                if (phase !== 3'd4 || phase_done !== 1'b1) begin
                    n_fail++; $display("FAIL force_cut got ph=%0d done=%b want 4/1", phase, phase_done);
                end
            end
            if (c == 45) begin
                n_checks++;
                if (phase !== 3'd5) begin n_fail++; $display("FAIL force_allred got %0d want 5", phase); end
            end
            if (c == 47) begin
                n_checks++;
                if (phase !== 3'd0) begin n_fail++; $display("FAIL force_main_back got %0d want 0", phase); end
            end
            @(negedge clk);
        end
        side_sensor = 1'b0;
        force_main = 1'b0;
    endtask

    task automatic test_freeze();
        int yellow = 0;
        int frozen_pulses = 0;
        do_reset();
        for (int c = 0; c < 42; c++) begin
            side_sensor = (c == 0);
            run = !(c >= 23 && c <= 29);
            if (phase === 3'd1) yellow++;
            if (c >= 21 && c <= 36 && phase_done === 1'b1) frozen_pulses++;
            if (c == 37) begin
                n_checks++;
                if (phase !== 3'd2 || phase_done !== 1'b1) begin
                    n_fail++; $display("FAIL freeze_exit got ph=%0d done=%b want 2/1", phase, phase_done);
                end
            end
            if (c == 39) begin
                n_checks++;
                if (phase !== 3'd3) begin n_fail++; $display("FAIL freeze_side got %0d want 3", phase); end
            end
            @(negedge clk);
        end
        run = 1'b1;
        side_sensor = 1'b0;
        n_checks++;
        if (yellow != 17) begin n_fail++; $display("FAIL freeze_yellow_len got %0d want 17", yellow); end
        n_checks++;
        if (frozen_pulses != 0) begin n_fail++; $display("FAIL freeze_pulses got %0d want 0", frozen_pulses); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 35; c++) begin
            side_sensor = (c == 0);
            @(negedge clk);
        end
        side_sensor = 1'b0;
        n_checks++;
        if (phase !== 3'd3) begin n_fail++; $display("FAIL areset_pre got %0d want 3", phase); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (main_light !== 3'b001 || side_light !== 3'b100 || phase !== 3'd0) begin
            n_fail++; $display("FAIL areset_lights got %b/%b ph=%0d want 001/100 ph=0", main_light, side_light, phase);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef PED_WALK_EN
    task automatic test_walk();
        int walk_cnt = 0;
        do_reset();
        for (int c = 0; c < 75; c++) begin
            side_sensor = (c == 0);
            ped_btn = (c == 35);
            if (walk === 1'b1) walk_cnt++;
            if (c == 60) begin
                n_checks++;
                if (phase !== 3'd6 || walk !== 1'b1 || main_light !== 3'b100 || side_light !== 3'b100) begin
                    n_fail++; $display("FAIL walk_state got ph=%0d walk=%b want 6/1", phase, walk);
                end
            end
            if (c == 71) begin
                n_checks++;
                if (phase !== 3'd0) begin n_fail++; $display("FAIL walk_exit got %0d want 0", phase); end
            end
            @(negedge clk);
        end
        n_checks++;
        if (walk_cnt != 12) begin n_fail++; $display("FAIL walk_len got %0d want 12", walk_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_full_cycle();
        test_back_to_back();
        test_force_main();
        test_freeze();
        test_async_reset();
`ifdef PED_WALK_EN
        test_walk();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
